// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and arbiter FSM state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit searching upward from ptr+1, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the winner.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan candidates in priority order ptr+1, ptr+2, ..., ptr (the last-served source comes last).
    always_comb begin
        logic [IW-1:0] c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = '0;
        for (int i = 1; i <= N; i++) begin
            c = IW'((int'(ptr) + i) % N);
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one serial transmitter between N_REQ byte sources; a grant is held for a whole message.
// Latency: request in IDLE at cycle n -> grant (and write if not busy) at n+1; writes at least 2 cycles apart.
// Backpressure: transmitter busy stalls the grantee (o_ready withheld); losers wait with valid held.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = 4800
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_valid,
    input  logic [BYTE_W*N_REQ-1:0] i_data,
    input  logic [N_REQ-1:0]        i_last,
    output logic [N_REQ-1:0]        o_ready,
    output logic                    o_wr,
    output logic [BYTE_W-1:0]       o_data,
    input  logic                    i_busy,
    output logic [N_REQ-1:0]        o_grant
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    // Last idle count before the lock is dropped, and the saturation ceiling of the counter.
    localparam logic [TW-1:0] T_LIM = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT = '1;

    state_t           state, state_nxt;
    logic [GW-1:0]    g, g_nxt;          // current grant index
    logic [N_REQ-1:0] g_oh, g_oh_nxt;    // same grant, one-hot
    logic [GW-1:0]    p, p_nxt;          // last-served requester
    logic             h, h_nxt;          // one-cycle holdoff after each write
    logic [TW-1:0]    t, t_nxt;          // idle-cycle counter while locked
    logic             xfer;

    logic [N_REQ-1:0] pick_gnt;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;

    logic [BYTE_W-1:0] lane [N_REQ];

    for (genvar r = 0; r < N_REQ; r++) begin : g_lane
        assign lane[r] = i_data[BYTE_W*r +: BYTE_W];
    end

    // Byte path follows the grant index at all times; only o_wr qualifies it.
    assign o_data = lane[g];

    rr_pick #(
        .N  (N_REQ),
        .IW (GW)
    ) u_pick (
        .req (i_valid),
        .ptr (p),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state and output decode: arbitrate in IDLE, move bytes / watch for end of message in LOCKED.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        g_oh_nxt  = g_oh;
        p_nxt     = p;
        t_nxt     = t;
        xfer      = 1'b0;
        o_wr      = 1'b0;
        o_ready   = '0;
        o_grant   = '0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_LOCKED;
                    g_nxt     = pick_idx;
                    g_oh_nxt  = pick_gnt;
                    t_nxt     = '0;
                end
            end
            ST_LOCKED: begin
                o_grant = g_oh;
                // Reset gates the strobe so a requester never sees an accept that is then discarded.
                xfer    = i_valid[g] && !i_busy && !h && !i_rst;
                o_wr    = xfer;
                o_ready = xfer ? g_oh : '0;
                // Waiting on busy keeps valid high, so only genuine silence from the grantee counts.
                if (i_valid[g]) begin
                    t_nxt = '0;
                end else if (t != T_SAT) begin
                    t_nxt = t + 1'b1;
                end
                if (xfer && i_last[g]) begin
                    p_nxt     = g;
                    state_nxt = ST_IDLE;
                end else if (!i_valid[g] && (t == T_LIM)) begin
                    p_nxt     = g;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // The transmitter raises busy one cycle after a write; block that gap.
        h_nxt = xfer;
    end

    // State register; requester 0 wins the first arbitration after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            g     <= '0;
            g_oh  <= '0;
            p     <= GW'(N_REQ - 1);
            h     <= 1'b0;
            t     <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            g_oh  <= g_oh_nxt;
            p     <= p_nxt;
            h     <= h_nxt;
            t     <= t_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-exact vector table, then message-level sequences.
// Latency: not applicable.
// Backpressure: transmitter busy is either tabulated or produced by a 10-cycle busy model.
module tb_uart_tx_arbiter;

    localparam int N_REQ    = 2;
    localparam int LOCK_TO  = 8;
    localparam int BUSY_LEN = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  valid;
    logic [15:0] data;
    logic [1:0]  last;
    logic        busy;
    logic [1:0]  o_ready;
    logic        o_wr;
    logic [7:0]  o_data;
    logic [1:0]  o_grant;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_data  (data),
        .i_last  (last),
        .o_ready (o_ready),
        .o_wr    (o_wr),
        .o_data  (o_data),
        .i_busy  (busy),
        .o_grant (o_grant)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [15:0] dat;
        logic [1:0]  lst;
        logic        bsy;
        logic        e_wr;
        logic [1:0]  e_rdy;
        logic [7:0]  e_dat;
        logic [1:0]  e_gnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [15:0] d,
                                input logic [1:0] l, input logic b, input logic ew,
                                input logic [1:0] er, input logic [7:0] ed, input logic [1:0] eg);
        vec_t x;
        x.rst = r; x.vld = v; x.dat = d; x.lst = l; x.bsy = b;
        x.e_wr = ew; x.e_rdy = er; x.e_dat = ed; x.e_gnt = eg;
        return x;
    endfunction

    // ---------------- message-level driver / monitor ----------------
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    int         log_idx [$];
    logic [7:0] log_dat [$];
    int         log_cyc [$];
    logic [1:0] gnt_hist [0:255];
    int         cyc;
    int         bcnt;
    logic       wr_prev;
    logic       bmodel;

    task automatic step();
        int idx;
        @(posedge clk);
        #1;
        if (wr_prev) bcnt = BUSY_LEN;
        else if (bcnt != 0) bcnt--;
        busy      = bmodel && (bcnt != 0);
        valid[0]  = (q0.size() != 0);
        data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        last[0]   = (q0.size() != 0) ? q0[0][8] : 1'b0;
        valid[1]  = (q1.size() != 0);
        data[15:8]= (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        last[1]   = (q1.size() != 0) ? q1[0][8] : 1'b0;
        @(negedge clk);
        if (cyc < 256) gnt_hist[cyc] = o_grant;
        if (o_wr) begin
            chk("ready_is_grant", {30'd0, o_ready}, {30'd0, o_grant});
            chk("holdoff_gap", {31'd0, wr_prev}, 32'd0);
            idx = (o_ready == 2'b01) ? 0 : (o_ready == 2'b10) ? 1 : -1;
            log_idx.push_back(idx);
            log_dat.push_back(o_data);
            log_cyc.push_back(cyc);
        end
        wr_prev = o_wr;
        if (o_ready[0] && q0.size() != 0) void'(q0.pop_front());
        if (o_ready[1] && q1.size() != 0) void'(q1.pop_front());
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input logic use_model);
        q0.delete(); q1.delete();
        log_idx.delete(); log_dat.delete(); log_cyc.delete();
        bcnt = 0; wr_prev = 1'b0; bmodel = use_model;
        @(posedge clk);
        #1;
        rst = 1'b1; valid = '0; last = '0; busy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_log(input string name, input int i, input int e_idx, input logic [7:0] e_dat);
        if (i >= log_dat.size()) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: write #%0d missing, got %0d writes", name, i, log_dat.size());
        end else begin
            chk({name, "_src"}, log_idx[i], e_idx);
            chk({name, "_byte"}, {24'd0, log_dat[i]}, {24'd0, e_dat});
        end
    endtask

    initial begin
        rst = 1'b1; valid = '0; data = '0; last = '0; busy = 1'b0;
        bmodel = 1'b0; bcnt = 0; wr_prev = 1'b0; cyc = 0;

        //            rst  vld    dat       lst   bsy  wr   rdy    dat    gnt
        vt[0]  = mk(1'b1, 2'b00, 16'h2211, 2'b00, 1'b0, 1'b0, 2'b00, 8'h11, 2'b00);
        vt[1]  = mk(1'b1, 2'b01, 16'h2211, 2'b00, 1'b0, 1'b0, 2'b00, 8'h11, 2'b00);
        vt[2]  = mk(1'b0, 2'b01, 16'h2241, 2'b00, 1'b0, 1'b0, 2'b00, 8'h41, 2'b00);
        vt[3]  = mk(1'b0, 2'b01, 16'h2241, 2'b00, 1'b0, 1'b1, 2'b01, 8'h41, 2'b01);
        vt[4]  = mk(1'b0, 2'b01, 16'h2242, 2'b01, 1'b0, 1'b0, 2'b00, 8'h42, 2'b01);
        vt[5]  = mk(1'b0, 2'b01, 16'h2242, 2'b01, 1'b1, 1'b0, 2'b00, 8'h42, 2'b01);
        vt[6]  = mk(1'b0, 2'b01, 16'h2242, 2'b01, 1'b0, 1'b1, 2'b01, 8'h42, 2'b01);
        vt[7]  = mk(1'b0, 2'b00, 16'h2242, 2'b00, 1'b0, 1'b0, 2'b00, 8'h42, 2'b00);
        vt[8]  = mk(1'b0, 2'b11, 16'h5544, 2'b11, 1'b0, 1'b0, 2'b00, 8'h44, 2'b00);
        vt[9]  = mk(1'b0, 2'b11, 16'h5544, 2'b11, 1'b0, 1'b1, 2'b10, 8'h55, 2'b10);
        vt[10] = mk(1'b0, 2'b11, 16'h5544, 2'b11, 1'b0, 1'b0, 2'b00, 8'h55, 2'b00);
        vt[11] = mk(1'b0, 2'b11, 16'h5544, 2'b11, 1'b0, 1'b1, 2'b01, 8'h44, 2'b01);
        vt[12] = mk(1'b0, 2'b10, 16'h5544, 2'b11, 1'b0, 1'b0, 2'b00, 8'h44, 2'b00);
        vt[13] = mk(1'b0, 2'b10, 16'h5544, 2'b11, 1'b1, 1'b0, 2'b00, 8'h55, 2'b10);
        vt[14] = mk(1'b1, 2'b10, 16'h5544, 2'b11, 1'b0, 1'b0, 2'b00, 8'h55, 2'b10);
        vt[15] = mk(1'b0, 2'b11, 16'h5544, 2'b11, 1'b0, 1'b0, 2'b00, 8'h44, 2'b00);
        vt[16] = mk(1'b0, 2'b11, 16'h5544, 2'b11, 1'b0, 1'b1, 2'b01, 8'h44, 2'b01);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            rst = vt[i].rst; valid = vt[i].vld; data = vt[i].dat;
            last = vt[i].lst; busy = vt[i].bsy;
            @(negedge clk);
            chk($sformatf("v%0d_wr", i),    {31'd0, o_wr},    {31'd0, vt[i].e_wr});
            chk($sformatf("v%0d_ready", i), {30'd0, o_ready}, {30'd0, vt[i].e_rdy});
            chk($sformatf("v%0d_data", i),  {24'd0, o_data},  {24'd0, vt[i].e_dat});
            chk($sformatf("v%0d_grant", i), {30'd0, o_grant}, {30'd0, vt[i].e_gnt});
        end

        // Single requester "AB", busy model: writes at cycles 1 and 12, grant gone at 13.
        do_reset(1'b1);
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b1, 8'h42});
        run(20);
        chk("a_count", log_dat.size(), 2);
        chk_log("a0", 0, 0, 8'h41);
        chk_log("a1", 1, 0, 8'h42);
        if (log_cyc.size() == 2) begin
            chk("a0_cyc", log_cyc[0], 1);
            chk("a1_cyc", log_cyc[1], 12);
        end
        chk("a_gnt_held", {30'd0, gnt_hist[12]}, 32'h1);
        chk("a_gnt_drop", {30'd0, gnt_hist[13]}, 32'h0);

        // Contention: two 2-byte messages, no interleave; then r0 alone re-granted.
        do_reset(1'b1);
        q0.push_back({1'b0, 8'h41}); q0.push_back({1'b1, 8'h42});
        q1.push_back({1'b0, 8'h61}); q1.push_back({1'b1, 8'h62});
        run(60);
        q0.push_back({1'b1, 8'h43});
        run(30);
        chk("b_count", log_dat.size(), 5);
        chk_log("b0", 0, 0, 8'h41);
        chk_log("b1", 1, 0, 8'h42);
        chk_log("b2", 2, 1, 8'h61);
        chk_log("b3", 3, 1, 8'h62);
        chk_log("b4", 4, 0, 8'h43);

        // Fairness: continuous single-byte messages alternate r0, r1.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'hA0 + 8'(i)});
            q1.push_back({1'b1, 8'hB0 + 8'(i)});
        end
        run(120);
        chk("c_count", log_dat.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk_log($sformatf("c%0d_r0", i), 2*i,     0, 8'hA0 + 8'(i));
            chk_log($sformatf("c%0d_r1", i), 2*i + 1, 1, 8'hB0 + 8'(i));
        end

        // Holdoff with busy never asserted: bytes land exactly every other cycle.
        do_reset(1'b0);
        q0.push_back({1'b0, 8'h51}); q0.push_back({1'b0, 8'h52}); q0.push_back({1'b1, 8'h53});
        run(10);
        chk("d_count", log_dat.size(), 3);
        if (log_cyc.size() == 3) begin
            chk("d0_cyc", log_cyc[0], 1);
            chk("d1_cyc", log_cyc[1], 3);
            chk("d2_cyc", log_cyc[2], 5);
        end
        chk("d_gnt_drop", {30'd0, gnt_hist[6]}, 32'h0);

        // Timeout: r0 sends one non-last byte and goes quiet while r1 waits.
        do_reset(1'b0);
        q0.push_back({1'b0, 8'h41});
        q1.push_back({1'b1, 8'h61});
        run(16);
        chk("e_count", log_dat.size(), 2);
        chk_log("e0", 0, 0, 8'h41);
        chk_log("e1", 1, 1, 8'h61);
        if (log_cyc.size() == 2) chk("e1_cyc", log_cyc[1], 11);
        chk("e_lock_held", {30'd0, gnt_hist[9]},  32'h1);
        chk("e_released",  {30'd0, gnt_hist[10]}, 32'h0);
        chk("e_regrant",   {30'd0, gnt_hist[11]}, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `serial_tx` transmitter between `N_REQ` byte sources, for example the RX echo FIFO and a status/message generator. Sources are granted in round-robin order. A grant is held for a whole message, ended by the `i_last` flag or by an idle timeout, so bytes from different sources never interleave on the wire. The block sits between the requesters and `serial_tx`. It drives `serial_tx`'s `i_wr`/`i_data` and consumes `o_busy`.

## Interface
- `N_REQ`, default 2: number of requesters, 2..4.
- `LOCK_TIMEOUT`, default 4800: consecutive cycles the grantee may hold `i_valid` low mid-message before its lock is released.
- `i_clk`, in, 1: system clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_valid`, in, `N_REQ`: per-requester byte available.
- `i_data`, in, `8*N_REQ`: per-requester byte. Requester r uses bits `[8r+7:8r]`.
- `i_last`, in, `N_REQ`: byte is the final byte of the message.
- `o_ready`, out, `N_REQ`: one-cycle accept pulse to the grantee.
- `o_wr`, out, 1: write strobe to `serial_tx`.
- `o_data`, out, 8: byte to `serial_tx`.
- `i_busy`, in, 1: `serial_tx` busy.
- `o_grant`, out, `N_REQ`: one-hot current grant. All zero when IDLE. Intended for LED/debug.

## Operation
- **States:** IDLE and LOCKED. Registered state: grant index `g`, last-served pointer `p`, holdoff flag `h`, timeout counter `t`.
- **IDLE:**
  - If any `i_valid` is set, pick the first set bit searching from `p+1` modulo `N_REQ`.
  - Register `g`, clear `t`, go to LOCKED.
  - No byte is issued in IDLE.
- **LOCKED, transfer condition:** `xfer = i_valid[g] && !i_busy && !h && !i_rst`.
  - `o_wr = xfer`.
  - `o_ready[g] = xfer`. Other `o_ready` bits are 0.
  - `o_data = i_data[g]`, muxed continuously.
- **Holdoff:** `h` is set for exactly the one cycle after each `xfer`. This covers `serial_tx` raising `o_busy` one cycle after `i_wr`.
- **Last byte:** `xfer && i_last[g]` sets `p <= g` and returns to IDLE.
- **Timeout:**
  - `t` increments while `!i_valid[g]` and clears while `i_valid[g]`.
  - When `t == LOCK_TIMEOUT-1` with `!i_valid[g]`, set `p <= g` and return to IDLE.
- **Requester rules:**
  - Hold `i_data`/`i_last` stable while `i_valid` is high and until `o_ready`.
  - Dropping `i_valid` before `o_ready` is a withdrawal. No byte is sent, and the drop counts toward the timeout.
- **Width:** `t` is `$clog2(LOCK_TIMEOUT)` bits and saturates; it never wraps.

## Timing
- **Reset values:**
  - Outputs: `o_wr=0`, `o_ready=0`, `o_grant=0`, `o_data=i_data[0]`. `o_wr` and `o_ready` are forced low during any cycle `i_rst` is high.
  - Internal: state IDLE, `p=N_REQ-1` (requester 0 wins first), `h=0`, `t=0`.
- **Latency:** `i_valid` rising in IDLE at cycle n gives `o_grant` at n+1, and `o_wr` at n+1 if `i_busy` is low.
- **Back-to-back bytes:** at least 2 cycles between `o_wr` pulses. In practice the spacing is set by `serial_tx` busy (~10 bit times).
- **Simultaneous requests:** resolved round-robin from `p+1`. A requester holding valid is served within `N_REQ` messages.
- **Last byte while another requester waits:** return to IDLE, arbitrate next cycle, grant the cycle after. No byte is lost.
- **Single-byte message** (`i_last` on first byte): grant released after one transfer.
- **`i_busy` high at grant time:** the lock is held and the byte issues on the first cycle `i_busy` is low. Waiting for busy does not advance `t`.
- **Reset mid-message:** on the next edge, return to IDLE with the grant dropped. The byte in flight in `serial_tx` is not recalled. The requester sees no `o_ready`.

## Structure
- **Package `uart_pkg`:** `BYTE_W=8` and the state enum `{ST_IDLE, ST_LOCKED}`. The package is shared with the serial_rx/serial_tx/fifo blocks.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot winner and index. It is reusable for other shared resources.
- **Top level:** the arbiter FSM, holdoff and timeout logic stay in `uart_tx_arbiter`. `top` instantiates it between the FIFO/message sources and `SER_TX`.

## Test plan
- **Single requester:** r0 sends "AB" with `i_last` on 'B', `serial_tx` model busy for 10 cycles after each wr. Expect `o_wr` with 0x41 one cycle after valid, 0x42 when busy falls, then `o_grant` returns to 0.
- **Contention:** r0 and r1 both valid with 2-byte messages from reset. Expect r0's two bytes, then r1's two bytes, with no interleave. Then r0 requests again: r1 has no request, so r0 is granted.
- **Fairness:** both requesters hold continuous 1-byte messages. Expect the grant to alternate r0, r1, r0, r1.
- **Timeout:** set `LOCK_TIMEOUT=8`. r0 sends one non-last byte then drops valid; r1 is waiting. Expect the lock released after 8 idle cycles, r1 granted 1 cycle later, and r0 never sees `o_ready` again until re-granted.
- **Reset mid-message:** pulse `i_rst` for 1 cycle during r1's message. Expect `o_wr`/`o_ready` low that cycle, IDLE the next cycle, and the next arbitration won by r0.
- **Holdoff:** busy model that raises busy one cycle late. Expect no double `o_wr` in adjacent cycles.
